// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared RV32I load/store encodings and LSU state type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_load_extend.sv
// ============================================================================
// Module : load_extend
// Brief  : Selects the addressed byte/half lane of a read word and extends it.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (addr)
      2'd0: w_byte = rdata[7:0];
      2'd1: w_byte = rdata[15:8];
      2'd2: w_byte = rdata[23:16];
      2'd3: w_byte = rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Unknown encodings fall through to a full-word pass-through.
  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   result = {24'h000000, w_byte};
      F3_H:    result = {{16{w_half[15]}}, w_half};
      F3_HU:   result = {16'h0000, w_half};
      default: result = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module : lsu
// Brief  : M-stage load/store unit driving a req/gnt/rvalid data bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsu
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            MisalignM,
  output logic            BusErrM,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic            w_access, w_isByte, w_isHalf, w_isWord;
  logic            w_misalign, w_op, w_isStore, w_timeout;
  logic [CNT_W-1:0] w_cntNext;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata, w_ext;

  assign w_access   = MemReadM | MemWriteM;
  assign w_isByte   = (Funct3M[1:0] == 2'b00);
  assign w_isHalf   = (Funct3M[1:0] == 2'b01);
  assign w_isWord   = Funct3M[1];
  assign w_misalign = (w_isHalf & ALUResultM[0]) | (w_isWord & (|ALUResultM[1:0]));
  assign w_op       = w_access & ~w_misalign;
  assign w_isStore  = MemWriteM & ~MemReadM;

  assign MisalignM  = w_access & w_misalign;
  // Gated by reset so an abandoned access releases the pipeline at once.
  assign StallM     = w_op & (r_state != DONE) & ~reset;

  assign w_cntNext  = r_cnt + 1'b1;
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cntNext == c_TIMEOUT);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteDataM;
    if (w_isStore) begin
      if (w_isByte) begin
        w_be    = 4'b0001 << ALUResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end else if (w_isHalf) begin
        w_be    = 4'b0011 << {ALUResultM[1], 1'b0};
        w_wdata = {2{WriteDataM[15:0]}};
      end
    end
  end

  load_extend u_ext (
    .rdata  (bus_rdata),
    .addr   (ALUResultM[1:0]),
    .funct3 (Funct3M),
    .result (w_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
    end else begin
      BusErrM <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_op) begin
            bus_req   <= 1'b1;
            bus_we    <= w_isStore;
            bus_addr  <= {ALUResultM[XLEN-1:2], 2'b00};
            bus_be    <= w_be;
            bus_wdata <= w_wdata;
            r_state   <= REQ;
          end else if (MisalignM) begin
            ReadDataM <= '0;
          end
        end
        REQ: begin
          // rvalid is not looked at here; data arrives only after the grant.
          if (bus_gnt) begin
            bus_req <= 1'b0;
            r_cnt   <= '0;
            r_state <= bus_we ? DONE : WAIT;
          end else if (w_timeout) begin
            bus_req   <= 1'b0;
            ReadDataM <= '0;
            BusErrM   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= DONE;
          end else begin
            r_cnt <= w_cntNext;
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            ReadDataM <= w_ext;
            r_cnt     <= '0;
            r_state   <= DONE;
          end else if (w_timeout) begin
            ReadDataM <= '0;
            BusErrM   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= DONE;
          end else begin
            r_cnt <= w_cntNext;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module : tb_lsu
// Brief  : Self-checking bench for lsu with a load-result scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, MisalignM, BusErrM;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  // Second instance with a short timeout; its bus is never granted except as driven.
  logic        mr2;
  logic [31:0] addr2, rd2Out;
  logic        stall2, mis2, err2, req2, we2, gnt2, rv2;
  logic [31:0] baddr2, bwdata2, brdata2;
  logic [3:0]  bbe2;

  int checks = 0;
  int errors = 0;
  logic [31:0] sbq[$];

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  lsu #(.TIMEOUT_CYCLES(4)) dut2 (
    .clk(clk), .reset(reset), .MemReadM(mr2), .MemWriteM(1'b0),
    .Funct3M(3'b010), .ALUResultM(addr2), .WriteDataM(32'h0),
    .ReadDataM(rd2Out), .StallM(stall2), .MisalignM(mis2), .BusErrM(err2),
    .bus_req(req2), .bus_we(we2), .bus_addr(baddr2), .bus_be(bbe2),
    .bus_wdata(bwdata2), .bus_gnt(gnt2), .bus_rvalid(rv2), .bus_rdata(brdata2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait-state load: grant in REQ cycle 1, rvalid in cycle 2.
  task automatic doLoad(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rd, input logic [31:0] exp);
    MemReadM = 1'b1; Funct3M = f3; ALUResultM = a;
    sbq.push_back(exp);
    @(negedge clk);
    chk("ld_stall_c0", {31'b0, StallM}, 32'd1);
    chk("ld_req_c0", {31'b0, bus_req}, 32'd0);
    nextCycle();
    bus_gnt = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h5555AAAA;
    @(negedge clk);
    chk("ld_req_c1", {31'b0, bus_req}, 32'd1);
    chk("ld_addr", bus_addr, {a[31:2], 2'b00});
    chk("ld_be", {28'b0, bus_be}, 32'hF);
    chk("ld_we", {31'b0, bus_we}, 32'd0);
    chk("ld_stall_c1", {31'b0, StallM}, 32'd1);
    nextCycle();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd;
    @(negedge clk);
    chk("ld_stall_c2", {31'b0, StallM}, 32'd1);
    chk("ld_req_c2", {31'b0, bus_req}, 32'd0);
    nextCycle();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("ld_stall_c3", {31'b0, StallM}, 32'd0);
    chk("ld_data", ReadDataM, sbq.pop_front());
    nextCycle();
    MemReadM = 1'b0;
    @(negedge clk);
    chk("ld_idle_req", {31'b0, bus_req}, 32'd0);
    nextCycle();
  endtask

  initial begin
    reset = 1'b1;
    MemReadM = 0; MemWriteM = 0; Funct3M = 3'b010; ALUResultM = 0; WriteDataM = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    mr2 = 0; addr2 = 0; gnt2 = 0; rv2 = 0; brdata2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_rd", ReadDataM, 32'd0);
    chk("rst_be", {28'b0, bus_be}, 32'd0);
    reset = 1'b0;
    nextCycle();

    doLoad(3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'hDEADBEEF);
    doLoad(3'b000, 32'h0000_0103, 32'h80112233, 32'hFFFFFF80);
    doLoad(3'b100, 32'h0000_0103, 32'h80112233, 32'h00000080);
    doLoad(3'b101, 32'h0000_0102, 32'h80112233, 32'h00008011);
    doLoad(3'b001, 32'h0000_0002, 32'h80112233, 32'hFFFF8011);
    doLoad(3'b000, 32'h0000_0001, 32'h80112233, 32'h00000022);

    // Store byte with grant withheld for five REQ cycles.
    MemWriteM = 1'b1; Funct3M = 3'b000; ALUResultM = 32'h0000_0201; WriteDataM = 32'h0000_00AB;
    @(negedge clk);
    chk("sb_stall_c0", {31'b0, StallM}, 32'd1);
    nextCycle();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus_gnt = 1'b1;
      @(negedge clk);
      chk("sb_req", {31'b0, bus_req}, 32'd1);
      chk("sb_be", {28'b0, bus_be}, 32'b0010);
      chk("sb_wdata", bus_wdata, 32'hABABABAB);
      chk("sb_addr", bus_addr, 32'h0000_0200);
      chk("sb_we", {31'b0, bus_we}, 32'd1);
      chk("sb_stall", {31'b0, StallM}, 32'd1);
      nextCycle();
    end
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("sb_done_stall", {31'b0, StallM}, 32'd0);
    chk("sb_done_req", {31'b0, bus_req}, 32'd0);
    nextCycle();
    MemWriteM = 1'b0;
    nextCycle();

    // Halfword store at offset 2 exercises the upper half lane.
    MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h0000_0302; WriteDataM = 32'h1234_BEEF;
    nextCycle();
    bus_gnt = 1'b1;
    @(negedge clk);
    chk("sh_be", {28'b0, bus_be}, 32'b1100);
    chk("sh_wdata", bus_wdata, 32'hBEEFBEEF);
    nextCycle();
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("sh_done_stall", {31'b0, StallM}, 32'd0);
    nextCycle();
    MemWriteM = 1'b0;
    nextCycle();

    // Misaligned halfword load clears the previous load result.
    MemReadM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h0000_0101;
    sbq.push_back(32'h0);
    @(negedge clk);
    chk("mis_flag", {31'b0, MisalignM}, 32'd1);
    chk("mis_stall", {31'b0, StallM}, 32'd0);
    chk("mis_req", {31'b0, bus_req}, 32'd0);
    nextCycle();
    MemReadM = 1'b0;
    @(negedge clk);
    chk("mis_rd", ReadDataM, sbq.pop_front());
    chk("mis_req_after", {31'b0, bus_req}, 32'd0);
    chk("mis_flag_after", {31'b0, MisalignM}, 32'd0);
    nextCycle();

    // Timeout on the short-timeout instance after a good load.
    mr2 = 1'b1; addr2 = 32'h40;
    nextCycle();
    gnt2 = 1'b1;
    nextCycle();
    gnt2 = 1'b0; rv2 = 1'b1; brdata2 = 32'h12345678;
    nextCycle();
    rv2 = 1'b0;
    @(negedge clk);
    chk("to_pre_rd", rd2Out, 32'h12345678);
    nextCycle();
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req_held", {31'b0, req2}, 32'd1);
      chk("to_err_low", {31'b0, err2}, 32'd0);
      nextCycle();
    end
    @(negedge clk);
    chk("to_req_drop", {31'b0, req2}, 32'd0);
    chk("to_buserr", {31'b0, err2}, 32'd1);
    chk("to_rd", rd2Out, 32'd0);
    chk("to_stall", {31'b0, stall2}, 32'd0);
    nextCycle();
    mr2 = 1'b0;
    @(negedge clk);
    chk("to_err_pulse", {31'b0, err2}, 32'd0);
    chk("to_idle_req", {31'b0, req2}, 32'd0);
    nextCycle();

    // Reset during WAIT abandons the access.
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_0500;
    nextCycle();
    bus_gnt = 1'b1;
    nextCycle();
    bus_gnt = 1'b0;
    reset = 1'b1;
    #1;
    chk("rw_req", {31'b0, bus_req}, 32'd0);
    chk("rw_stall", {31'b0, StallM}, 32'd0);
    @(negedge clk);
    MemReadM = 1'b0;
    nextCycle();
    reset = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    nextCycle();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("rw_rd_ignored", ReadDataM, 32'd0);
    chk("rw_req_after", {31'b0, bus_req}, 32'd0);
    nextCycle();

    doLoad(3'b010, 32'h0000_0600, 32'h0BADF00D, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit for the Memory stage of the 5-stage RV32I pipeline.
- Consumes the M-stage address, store data and funct3, and talks to a multi-cycle data bus using a req/gnt/rvalid handshake.
- Generates byte enables and store-lane alignment; sign- or zero-extends load data into ReadDataM.
- Asserts StallM, which the hazard unit uses to freeze F/D/E/M and bubble W until the access completes.

Parameters:
- TIMEOUT_CYCLES, 64: consecutive cycles in REQ+WAIT before aborting with BusErrM. 0 disables the timeout.
- XLEN, 32: data and address width. Only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- MemReadM  in  1  load instruction in M
- MemWriteM  in  1  store instruction in M
- Funct3M  in  3  load/store size and sign, taken from InstrM[14:12]
- ALUResultM  in  32  effective byte address
- WriteDataM  in  32  store data, taken from rs2 after forwarding
- ReadDataM  out  32  extended load result, to the M/W register
- StallM  out  1  pipeline hold request
- MisalignM  out  1  misaligned-access pulse
- BusErrM  out  1  bus timeout pulse
- bus_req  out  1  access request
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data word

Behaviour:
- Reset (async): state IDLE. Counter 0. All outputs 0, including bus_req. A reset arriving mid-transaction drops bus_req immediately; the bus slave must tolerate the abandoned request.
- Op = (MemReadM|MemWriteM) & !misaligned. If both read and write are set, the access is treated as a load.
- Misaligned:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0.
  - No bus access. StallM=0. MisalignM=1 for that cycle, combinationally. ReadDataM is loaded with 0 on the next edge.
- Unknown funct3 (011, 110, 111) is treated as a word access.
- StallM = Op & (state != DONE), combinational.
- FSM transitions:
  - IDLE: if Op, register bus_addr/we/be/wdata, set bus_req=1, go to REQ.
  - REQ: bus_req=1; addr/we/be/wdata are held stable. On bus_gnt, drop bus_req; a store goes to DONE, a load goes to WAIT. A bus_rvalid in the same cycle as bus_gnt is ignored; rvalid arrives no earlier than the next cycle.
  - WAIT: on bus_rvalid, ReadDataM <= extend(bus_rdata), go to DONE.
  - DONE: StallM=0 so the pipeline advances. ReadDataM holds its value. Next state is IDLE unconditionally, so the same instruction is never re-issued.
- Zero-wait-state timing (cycle 0 = op first seen in M):
  - Load: stalled for cycles 0-2, DONE in cycle 3.
  - Store: stalled for cycles 0-1, DONE in cycle 2.
- Timeout:
  - The counter increments each cycle in REQ or WAIT and clears on leaving those states.
  - When it reaches TIMEOUT_CYCLES: drop bus_req, ReadDataM <= 0, go to DONE. BusErrM=1 during that DONE cycle.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{byte}}.
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{half}}.
  - SW: be = 4'b1111.
  - Loads drive be = 4'b1111.
- Load extend: select the lane by addr[1:0].
  - LB: sign-extend the byte. LBU: zero-extend the byte.
  - LH: sign-extend the half. LHU: zero-extend the half.
  - LW: pass the word through.
- ReadDataM is registered and changes only on a load capture, a timeout, a misaligned access, or reset.

Decomposition:
- riscv_pkg holds:
  - Funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - lsu_state_t: IDLE, REQ, WAIT, DONE.
- Sub-module load_extend (combinational): inputs rdata, addr[1:0], funct3; output 32-bit extended value. Shared with any future cache path.

Test Plan:
- LW at 0x100, gnt in REQ cycle 1, rvalid=0xDEADBEEF in cycle 2 -> StallM=1 for cycles 0-2; cycle 3 ReadDataM=0xDEADBEEF, StallM=0.
- LB at 0x103, rdata=0x80112233 -> ReadDataM=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x102 -> 0x00008011.
- SB at 0x0000_0201, data 0x000000AB -> bus_be=0010, bus_wdata=0xABABABAB, bus_addr=0x200, bus_we=1. bus_gnt withheld 5 cycles -> request fields stable throughout, StallM held high.
- LH at 0x101 -> MisalignM=1, bus_req never asserted, StallM=0, next-cycle ReadDataM=0.
- TIMEOUT_CYCLES=4, LW with no bus_gnt -> bus_req drops after 4 REQ cycles, BusErrM=1 for one cycle, ReadDataM=0, FSM returns to IDLE.
- Reset asserted during WAIT -> bus_req=0 and StallM=0 immediately. A rvalid after reset is deasserted is ignored; state is IDLE.
